ramb4_s16_fifo_ctrl: RTL
========================

Name: ramb4_s16_fifo_ctrl

Overview:
- Synchronous 16-bit FIFO controller that sits directly upstream of one 256x16 single-port block RAM (RAMB4_S16 class) and uses it as FIFO storage.
- Drives the RAM's ADDR/DI/EN/WE/RST pins and consumes its DO output.
- Exposes valid/ready write and read streams, and arbitrates the single RAM port between writes and prefetch reads.
- A 2-entry output buffer absorbs the RAM's 1-cycle read latency, so the read stream can sustain back-to-back transfers.

Parameters:
- DATA_W, 16, data width; fixed by the RAM primitive.
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W = 256.
- OBUF_DEPTH, 2, output buffer entries; only 2 is supported.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- wr_valid  input  1  write request.
- wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
- wr_data  input  16  write word.
- rd_valid  output  1  rd_data is valid.
- rd_ready  input  1  consumer accepts the word.
- rd_data  output  16  head word.
- count  output  9  words held: ram_cnt + obuf_cnt + inflight, range 0..258.
- ram_addr  output  8  to RAM ADDR.
- ram_di  output  16  to RAM DI; equals wr_data.
- ram_en  output  1  to RAM EN.
- ram_we  output  1  to RAM WE.
- ram_rst  output  1  to RAM RST; equals ~RST_N.
- ram_do  input  16  from RAM DO; valid one cycle after a read access.

Behaviour:
- Interface: one clock (CLK); reset RST_N is synchronous and active-low.
- State:
  - wptr, rptr: 8-bit, wrap modulo 256.
  - ram_cnt: 0..256.
  - inflight: 1 bit, read issued in the previous cycle.
  - obuf: 2-entry FIFO, obuf_cnt 0..2.
  - last_grant: RD or WR.
- Request terms:
  - rd_req = (ram_cnt != 0) && (obuf_cnt + inflight < 2), where obuf_cnt counts after this cycle's pop.
  - wr_req = wr_valid && (ram_cnt != 256).
- Arbitration, one RAM access per cycle:
  - If only one of rd_req/wr_req is high, it is granted.
  - If both are high, grant the side not named in last_grant. last_grant updates only on conflict cycles.
- wr_ready = (ram_cnt != 256) && !rd_issue. wr_ready has no combinational path from wr_valid.
- RAM drive:
  - ram_en = rd_issue | wr_issue; ram_we = wr_issue.
  - ram_addr = rd_issue ? rptr : wptr.
- On wr_issue: wptr += 1, ram_cnt += 1.
- On rd_issue: rptr += 1, ram_cnt -= 1, inflight <= 1.
- If both a write and a read occur in the same cycle, ram_cnt is unchanged.
- When inflight = 1: ram_do is pushed into obuf at the end of that cycle. Space is guaranteed by rd_req.
- Output side:
  - rd_valid = (obuf_cnt != 0); rd_data = obuf head.
  - Pop on rd_valid && rd_ready.
  - Push and pop in the same cycle are legal.
- Latency: write accepted in cycle T (reads idle, rd_ready=1) -> RAM read in T+1 -> rd_valid with that data in T+3.
- Ordering: strict FIFO; no bypass path around the RAM.
- Full: ram_cnt = 256 -> wr_ready = 0. Maximum count is 258 once obuf is full.
- Empty: count = 0 -> rd_valid = 0, ram_en = 0.
- Reset (RST_N low at an edge), taking priority over all other events:
  - wptr, rptr, ram_cnt, inflight, obuf_cnt and count <= 0; last_grant <= WR.
  - Any in-flight read is discarded.
  - While RST_N is low: wr_ready = 0, rd_valid = 0, ram_en = 0, ram_we = 0, ram_rst = 1.
  - RAM contents are not cleared.
- Out-of-range accesses are impossible by construction. Pointer wrap from 255 to 0 is silent.

Decomposition:
- Shared package ramb4_fifo_pkg holds:
  - DATA_W, ADDR_W, RAM_DEPTH = 256;
  - grant_t enum {GNT_WR, GNT_RD};
  - count width constant CNT_W = 9.
- One sub-module, ramb4_fifo_obuf: 2-entry output buffer with push/pop, obuf_cnt and head output.
- Arbitration and pointers stay in the top module.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with wr_valid=1 -> wr_ready=0, rd_valid=0, ram_en=0, ram_rst=1, count=0. First cycle after release: wr_ready=1.
- Single word: write 16'hA5A5 in cycle T with rd_ready=1 -> T: ram_we=1, ram_addr=8'h00; T+1: ram_en=1, ram_we=0, ram_addr=8'h00; T+3: rd_valid=1, rd_data=16'hA5A5. Count then returns to 0.
- Fill/drain: rd_ready=0, offer words 16'h0000 upward -> exactly 258 accepted, wr_ready low with count=258. Then rd_ready=1 -> 16'h0000..16'h0101 emerge in order and count reaches 0.
- Contention: wr_valid=1 and rd_ready=1 continuously for 1000 words -> grants alternate on conflict cycles, each side sustains one word per 2 cycles, neither side starves, order is preserved.
- Wrap with stalls: 600 words with random wr_valid/rd_ready gaps -> pointers wrap past 255, there is no loss or duplication, and count matches the scoreboard every cycle.
- Mid-operation reset: assert RST_N=0 in the cycle after a read issue (inflight=1) -> after release rd_valid=0 and count=0, and the stale ram_do is never presented.

Source files
------------

// File: rtl/ramb4_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ramb4_fifo_pkg
//  Brief    : Shared constants and types for the RAMB4_S16 FIFO controller.
//  Revision : 1.0 - initial release
// ============================================================================
package ramb4_fifo_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int RAM_DEPTH = 2 ** ADDR_W;
    localparam int CNT_W     = 9;

    // Side that won the most recent conflicting RAM cycle.
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/ramb4_fifo_obuf.sv
`default_nettype none
// ============================================================================
//  Module   : ramb4_fifo_obuf
//  Brief    : Two-entry output buffer catching RAM read data; head is slot 0.
//  Revision : 1.0 - initial release
// ============================================================================
module ramb4_fifo_obuf
    import ramb4_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       cnt,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic [1:0]       r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_slot0 <= push_data;
                    end else begin
                        r_slot1 <= push_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_cnt   <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps the occupancy, data shifts forward.
                    if (r_cnt == 2'd1) begin
                        r_slot0 <= push_data;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cnt  = r_cnt;
    assign head = r_slot0;

endmodule
`default_nettype wire

// File: rtl/ramb4_s16_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ramb4_s16_fifo_ctrl
//  Brief    : FIFO controller using one 256x16 single-port block RAM as storage.
//  Revision : 1.0 - initial release
// ============================================================================
module ramb4_s16_fifo_ctrl #(
    parameter int DATA_W     = ramb4_fifo_pkg::DATA_W,
    parameter int ADDR_W     = ramb4_fifo_pkg::ADDR_W,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [DATA_W-1:0]                 rd_data,
    output logic [ramb4_fifo_pkg::CNT_W-1:0]  count,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic [DATA_W-1:0]                 ram_di,
    output logic                              ram_en,
    output logic                              ram_we,
    output logic                              ram_rst,
    input  logic [DATA_W-1:0]                 ram_do
);

    import ramb4_fifo_pkg::*;

    localparam logic [ADDR_W:0] c_full       = (ADDR_W + 1)'(RAM_DEPTH);
    localparam logic [2:0]      c_obuf_depth = 3'(OBUF_DEPTH);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_ram_cnt;
    logic              r_inflight;
    grant_t            r_last_grant;

    logic [1:0]        w_obuf_cnt;
    logic [DATA_W-1:0] w_obuf_head;
    logic [1:0]        w_obuf_after_pop;
    logic [2:0]        w_occ;
    logic              w_full;
    logic              w_pop;
    logic              w_rd_req;
    logic              w_wr_req;
    logic              w_rd_issue;
    logic              w_wr_issue;

    // Read prefetch only when the landing slot is guaranteed free next cycle.
    always_comb begin
        w_full           = (r_ram_cnt == c_full);
        w_pop            = RST_N && (w_obuf_cnt != 2'd0) && rd_ready;
        w_obuf_after_pop = w_obuf_cnt - {1'b0, w_pop};
        w_occ            = {1'b0, w_obuf_after_pop} + {2'b00, r_inflight};
        w_rd_req         = RST_N && (r_ram_cnt != '0) && (w_occ < c_obuf_depth);
        w_wr_req         = RST_N && wr_valid && !w_full;
        w_rd_issue       = w_rd_req && (!w_wr_req || (r_last_grant == GNT_WR));
        w_wr_issue       = w_wr_req && !w_rd_issue;
    end

    // Written without wr_valid: equals !full && !rd_issue whenever a write is offered.
    assign wr_ready = RST_N && !w_full && !(w_rd_req && (r_last_grant == GNT_WR));

    assign ram_en   = w_rd_issue | w_wr_issue;
    assign ram_we   = w_wr_issue;
    assign ram_addr = w_rd_issue ? r_rptr : r_wptr;
    assign ram_di   = wr_data;
    assign ram_rst  = ~RST_N;

    assign rd_valid = RST_N && (w_obuf_cnt != 2'd0);
    assign rd_data  = w_obuf_head;
    assign count    = CNT_W'(r_ram_cnt) + CNT_W'(w_obuf_cnt) + CNT_W'(r_inflight);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_ram_cnt    <= '0;
            r_inflight   <= 1'b0;
            r_last_grant <= GNT_WR;
        end else begin
            if (w_wr_issue) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_issue, w_rd_issue})
                2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
                2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
                default: r_ram_cnt <= r_ram_cnt;
            endcase
            r_inflight <= w_rd_issue;
            if (w_rd_req && w_wr_req) begin
                r_last_grant <= w_rd_issue ? GNT_RD : GNT_WR;
            end
        end
    end

    ramb4_fifo_obuf #(
        .WIDTH     (DATA_W)
    ) u_obuf (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (r_inflight),
        .push_data (ram_do),
        .pop       (w_pop),
        .cnt       (w_obuf_cnt),
        .head      (w_obuf_head)
    );

endmodule
`default_nettype wire
